cdb_arbiter: RTL and testbench

- Shares the single Common Data Bus (CDB) write/broadcast port among several functional-unit completion requesters.
- The CDB drives the physical register file write port, its same-cycle read bypass, and the reservation-station and ROB wakeup logic.
- Grants one requester per cycle using rotating round-robin priority.
- Registers the winning payload onto the CDB, so broadcast latency is exactly one cycle after handshake.

---
 rtl/cdb_arbiter.sv | 123 ++++++++++++
 tb/tb_cdb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one completing functional unit per cycle
// with rotating round-robin priority and registers its result onto the CDB,
// which feeds the register-file write port, its bypass and the RS/ROB wakeup.
module cdb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PRD_WIDTH    = 6,
  parameter int ROB_ID_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*PRD_WIDTH-1:0]       req_prd,
  input  logic [NUM_REQ*32-1:0]              req_result,
  input  logic [NUM_REQ*ROB_ID_WIDTH-1:0]    req_rob_id,
  output logic                               cdb_valid,
  output logic [PRD_WIDTH-1:0]               cdb_prd,
  output logic [31:0]                        cdb_result,
  output logic [ROB_ID_WIDTH-1:0]            cdb_rob_id
);

  localparam int          PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NREQ_U = NUM_REQ;

  if (NUM_REQ < 2) begin : g_param_check
    $error("cdb_arbiter needs at least two requesters");
  end

  // Index arithmetic modulo NUM_REQ; base and offset are both below NUM_REQ,
  // so one conditional subtract is enough and non-power-of-two counts work.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned       off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ_U) sum = sum - NREQ_U;
    return sum[PTR_W-1:0];
  endfunction

  // Rotating priority pointer: the requester searched first this cycle.
  logic [PTR_W-1:0]        ptr_p0;

  logic [NUM_REQ-1:0]      grant_p0;
  logic [PTR_W-1:0]        gnt_idx_p0;
  logic [PTR_W-1:0]        scan_idx;
  logic                    found;
  logic                    xfer_p0;

  logic [PRD_WIDTH-1:0]    sel_prd_p0;
  logic [31:0]             sel_result_p0;
  logic [ROB_ID_WIDTH-1:0] sel_rob_id_p0;

  logic                    vld_p1;
  logic [PRD_WIDTH-1:0]    prd_p1;
  logic [31:0]             result_p1;
  logic [ROB_ID_WIDTH-1:0] rob_id_p1;

  // ---- stage p0: arbitration (valid-only, never looks at payload) ----

  // Round-robin search starting at ptr; reset and flush suppress any grant.
  always_comb begin
    grant_p0   = '0;
    gnt_idx_p0 = '0;
    scan_idx   = '0;
    found      = 1'b0;
    if (!rst && !flush) begin
      for (int unsigned k = 0; k < NREQ_U; k++) begin
        scan_idx = wrap_add(ptr_p0, k);
        if (!found && req_valid[scan_idx]) begin
          found      = 1'b1;
          gnt_idx_p0 = scan_idx;
        end
      end
      if (found) grant_p0[gnt_idx_p0] = 1'b1;
    end
  end

  // A grant is only ever issued to a valid requester, so any grant is a transfer.
  assign xfer_p0   = |grant_p0;
  assign req_ready = grant_p0;

  // Select the winner's payload from the one-hot grant.
  always_comb begin
    sel_prd_p0    = '0;
    sel_result_p0 = '0;
    sel_rob_id_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_p0[i]) begin
        sel_prd_p0    = req_prd[i*PRD_WIDTH +: PRD_WIDTH];
        sel_result_p0 = req_result[i*32 +: 32];
        sel_rob_id_p0 = req_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
      end
    end
  end

  // ---- stage p1: registered CDB broadcast ----

  // Advance the pointer past the winner and capture its payload; reset clears
  // the broadcast so a half-issued result never reaches wakeup logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p0    <= '0;
      vld_p1    <= 1'b0;
      prd_p1    <= '0;
      result_p1 <= '0;
      rob_id_p1 <= '0;
    end else begin
      vld_p1 <= xfer_p0;
      if (xfer_p0) begin
        ptr_p0    <= wrap_add(gnt_idx_p0, 1);
        prd_p1    <= sel_prd_p0;
        result_p1 <= sel_result_p0;
        rob_id_p1 <= sel_rob_id_p0;
      end
    end
  end

  assign cdb_valid  = vld_p1;
  assign cdb_prd    = prd_p1;
  assign cdb_result = result_p1;
  assign cdb_rob_id = rob_id_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grants, broadcast payloads, wrap, backpressure,
// flush and reset, each against hand-computed values.
module tb_cdb_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int PRD_WIDTH    = 6;
  localparam int ROB_ID_WIDTH = 5;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            flush;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*PRD_WIDTH-1:0]    req_prd;
  logic [NUM_REQ*32-1:0]           req_result;
  logic [NUM_REQ*ROB_ID_WIDTH-1:0] req_rob_id;
  logic                            cdb_valid;
  logic [PRD_WIDTH-1:0]            cdb_prd;
  logic [31:0]                     cdb_result;
  logic [ROB_ID_WIDTH-1:0]         cdb_rob_id;

  int vectors     = 0;
  int miscompares = 0;
  int hits;

  cdb_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .PRD_WIDTH   (PRD_WIDTH),
    .ROB_ID_WIDTH(ROB_ID_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_prd   (req_prd),
    .req_result(req_result),
    .req_rob_id(req_rob_id),
    .cdb_valid (cdb_valid),
    .cdb_prd   (cdb_prd),
    .cdb_result(cdb_result),
    .cdb_rob_id(cdb_rob_id)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] prd, input logic [31:0] res,
                         input logic [4:0] rob);
    req_prd[i*PRD_WIDTH +: PRD_WIDTH]          = prd;
    req_result[i*32 +: 32]                     = res;
    req_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH] = rob;
  endtask

  task automatic check_ready(input string tag, input logic [3:0] exp);
    #1;
    check_val(tag, 64'(req_ready), 64'(exp));
  endtask

  task automatic check_cdb(input string tag, input logic v, input logic [5:0] prd,
                           input logic [31:0] res, input logic [4:0] rob);
    check_val({tag, "_valid"}, 64'(cdb_valid), 64'(v));
    if (v) begin
      check_val({tag, "_prd"},    64'(cdb_prd),    64'(prd));
      check_val({tag, "_result"}, 64'(cdb_result), 64'(res));
      check_val({tag, "_rob"},    64'(cdb_rob_id), 64'(rob));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 4'b1111;
    req_prd    = '0;
    req_result = '0;
    req_rob_id = '0;

    // Reset: no grant while rst is high, broadcast registers cleared.
    tick();
    check_ready("rst_ready", 4'b0000);
    check_val("rst_cdb_valid", 64'(cdb_valid), 64'(1'b0));
    check_val("rst_cdb_prd", 64'(cdb_prd), 64'(6'd0));
    check_val("rst_cdb_result", 64'(cdb_result), 64'(32'd0));
    check_val("rst_cdb_rob", 64'(cdb_rob_id), 64'(5'd0));
    tick();
    rst       = 1'b0;
    req_valid = 4'b0000;
    check_ready("idle_ready", 4'b0000);
    tick();
    check_val("idle_cdb_valid", 64'(cdb_valid), 64'(1'b0));

    // All four held valid from ptr=0: grants 0,1,2,3,0 with continuous CDB.
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 6'(20 + i), 32'hC0DE_0000 + 32'(i), 5'(16 + i));
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      check_ready($sformatf("rr_ready%0d", c), 4'(1 << (c % 4)));
      tick();
      check_cdb($sformatf("rr_cdb%0d", c), 1'b1, 6'(20 + c % 4),
                32'hC0DE_0000 + 32'(c % 4), 5'(16 + c % 4));
    end
    req_valid = 4'b0000;
    tick();
    check_val("rr_end_valid", 64'(cdb_valid), 64'(1'b0));

    // Single requester 2 (ptr=1 here): same-cycle grant, one broadcast.
    set_req(2, 6'd9, 32'hDEAD_BEEF, 5'd3);
    req_valid = 4'b0100;
    check_ready("single_ready", 4'b0100);
    tick();
    req_valid = 4'b0000;
    check_cdb("single_cdb", 1'b1, 6'd9, 32'hDEAD_BEEF, 5'd3);
    check_ready("single_ready_off", 4'b0000);
    tick();
    check_val("single_once", 64'(cdb_valid), 64'(1'b0));

    // Wrap and skip: ptr=3, requesters 0 and 1 valid -> 0 then 1.
    set_req(0, 6'd10, 32'h0000_00A0, 5'd10);
    set_req(1, 6'd11, 32'h0000_00A1, 5'd11);
    req_valid = 4'b0011;
    check_ready("wrap_ready0", 4'b0001);
    tick();
    check_cdb("wrap_cdb0", 1'b1, 6'd10, 32'h0000_00A0, 5'd10);
    req_valid = 4'b0010;
    check_ready("wrap_ready1", 4'b0010);
    tick();
    check_cdb("wrap_cdb1", 1'b1, 6'd11, 32'h0000_00A1, 5'd11);
    req_valid = 4'b0000;
    tick();
    check_val("wrap_end_valid", 64'(cdb_valid), 64'(1'b0));

    // Backpressure: ptr=2, requester 1 waits behind 2 and 3, holding its payload.
    set_req(1, 6'd33, 32'h1111_1111, 5'd7);
    set_req(2, 6'd34, 32'h2222_2222, 5'd8);
    set_req(3, 6'd35, 32'h3333_3333, 5'd9);
    hits = 0;
    req_valid = 4'b1110;
    check_ready("bp_ready0", 4'b0100);
    tick();
    if (cdb_valid && cdb_prd == 6'd33) hits++;
    check_cdb("bp_cdb0", 1'b1, 6'd34, 32'h2222_2222, 5'd8);
    req_valid = 4'b1010;
    check_ready("bp_ready1", 4'b1000);
    tick();
    if (cdb_valid && cdb_prd == 6'd33) hits++;
    check_cdb("bp_cdb1", 1'b1, 6'd35, 32'h3333_3333, 5'd9);
    req_valid = 4'b0010;
    check_ready("bp_ready2", 4'b0010);
    tick();
    if (cdb_valid && cdb_prd == 6'd33) hits++;
    check_cdb("bp_cdb2", 1'b1, 6'd33, 32'h1111_1111, 5'd7);
    req_valid = 4'b0000;
    tick();
    if (cdb_valid && cdb_prd == 6'd33) hits++;
    check_val("bp_once", 64'(hits), 64'(1));

    // Flush: transfer in T (ptr 2 -> 3), flush in T+1, ptr must still be 3.
    set_req(2, 6'd40, 32'h4040_4040, 5'd12);
    req_valid = 4'b0100;
    check_ready("fl_ready_t", 4'b0100);
    tick();
    flush     = 1'b1;
    req_valid = 4'b1111;
    check_ready("fl_ready_flush", 4'b0000);
    tick();
    check_val("fl_cdb_valid", 64'(cdb_valid), 64'(1'b0));
    flush = 1'b0;
    set_req(3, 6'd41, 32'h4141_4141, 5'd13);
    set_req(0, 6'd42, 32'h4242_4242, 5'd14);
    check_ready("fl_ptr_held", 4'b1000);
    tick();
    check_cdb("fl_cdb_after", 1'b1, 6'd41, 32'h4141_4141, 5'd13);
    check_ready("fl_ready_next", 4'b0001);
    tick();

    // Reset mid-stream: a broadcast is pending, rst wipes it and ptr (now 1).
    check_cdb("mr_cdb_pending", 1'b1, 6'd42, 32'h4242_4242, 5'd14);
    rst   = 1'b1;
    flush = 1'b1;
    check_ready("mr_ready_rst", 4'b0000);
    tick();
    check_val("mr_cdb_valid", 64'(cdb_valid), 64'(1'b0));
    check_val("mr_cdb_prd", 64'(cdb_prd), 64'(6'd0));
    check_val("mr_cdb_result", 64'(cdb_result), 64'(32'd0));
    check_val("mr_cdb_rob", 64'(cdb_rob_id), 64'(5'd0));
    rst   = 1'b0;
    flush = 1'b0;
    check_ready("mr_first_grant", 4'b0001);
    tick();
    check_cdb("mr_cdb_first", 1'b1, 6'd42, 32'h4242_4242, 5'd14);
    req_valid = 4'b0000;
    tick();
    check_val("mr_end_valid", 64'(cdb_valid), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
